// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED refresh scheduler.
// Line geometry, FSM encoding and the page-advance helper.
package oled_pkg;

  localparam int LINE_W         = 128;
  localparam int LINES_PER_PAGE = 4;

  typedef logic [LINE_W-1:0] line_t;

  localparam line_t DASH_LINE = {16{8'h2D}};

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    WAIT_ACK,
    WAIT_DONE,
    ABORT
  } state_t;

  function automatic logic [1:0] next_page(
    input logic [1:0] cur,
    input int         np
  );
    return (cur == 2'(np - 1)) ? 2'd0 : cur + 2'd1;
  endfunction

endpackage

// File: rtl/oled_refresh_sched_tick_gen.sv
// Free-running PERIOD counter; tick is high for the single cycle
// in which the count sits at PERIOD-1, just before it wraps.
module tick_gen #(
  parameter int PERIOD = 3333333
) (
  input  logic GCLK,
  input  logic RSTN,
  output logic tick
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge GCLK) begin
    if (!RSTN) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/oled_refresh_sched.sv
// Periodic OLED frame scheduler: snapshots one sensor page and
// handshakes a refresh request against the driver busy flag.
module oled_refresh_sched
  import oled_pkg::*;
#(
  parameter int NPAGES  = 2,
  parameter int PERIOD  = 3333333,
  parameter int TIMEOUT = 1000000
) (
  input  logic                  GCLK,
  input  logic                  RSTN,
  input  logic                  en,
  input  logic                  page_next,
  input  logic [NPAGES*512-1:0] pg_str,
  input  logic                  oled_busy,
  output logic [127:0]          s1,
  output logic [127:0]          s2,
  output logic [127:0]          s3,
  output logic [127:0]          s4,
  output logic                  refresh,
  output logic [1:0]            page_cur,
  output logic [15:0]           frame_cnt,
  output logic                  err
);

  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WD_TO = WDW'(TIMEOUT);

  state_t         st;
  state_t         nxt;
  logic           tick;
  logic [WDW-1:0] wdog;
  logic           wd_to;
  logic           in_wait;
  logic           ld;
  logic           ref_set;
  logic           ref_clr;
  logic           err_set;
  logic           fc_inc;
  logic           wd_clr;
  line_t          pg_line [16];

  tick_gen #(
    .PERIOD(PERIOD)
  ) u_tick (
    .GCLK(GCLK),
    .RSTN(RSTN),
    .tick(tick)
  );

  // Flat 4x4 line table; pages beyond NPAGES read as dashes.
  for (genvar i = 0; i < 16; i++) begin : g_line
    if (i < NPAGES * LINES_PER_PAGE) begin : g_real
      assign pg_line[i] = pg_str[i*LINE_W +: LINE_W];
    end else begin : g_pad
      assign pg_line[i] = DASH_LINE;
    end
  end

  assign wd_to   = (wdog == WD_TO);
  assign in_wait = (st == WAIT_ACK) || (st == WAIT_DONE);

  always_ff @(posedge GCLK) begin
    if (!RSTN) begin
      st <= IDLE;
    end else begin
      st <= nxt;
    end
  end

  always_comb begin
    nxt     = st;
    ld      = 1'b0;
    ref_set = 1'b0;
    ref_clr = 1'b0;
    err_set = 1'b0;
    fc_inc  = 1'b0;
    wd_clr  = 1'b0;
    unique case (st)
      IDLE: begin
        if (en && tick) nxt = LATCH;
      end
      LATCH: begin
        ld      = 1'b1;
        ref_set = 1'b1;
        wd_clr  = 1'b1;
        nxt     = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (oled_busy) begin
          ref_clr = 1'b1;
          wd_clr  = 1'b1;
          nxt     = WAIT_DONE;
        end else if (wd_to) begin
          ref_clr = 1'b1;
          err_set = 1'b1;
          nxt     = ABORT;
        end
      end
      WAIT_DONE: begin
        if (!oled_busy) begin
          fc_inc = 1'b1;
          nxt    = IDLE;
        end else if (wd_to) begin
          ref_clr = 1'b1;
          err_set = 1'b1;
          nxt     = ABORT;
        end
      end
      ABORT: begin
        ref_clr = 1'b1;
        err_set = 1'b1;
        nxt     = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Lines are only written in LATCH so an in-flight frame never tears.
  always_ff @(posedge GCLK) begin
    if (!RSTN) begin
      s1        <= DASH_LINE;
      s2        <= DASH_LINE;
      s3        <= DASH_LINE;
      s4        <= DASH_LINE;
      refresh   <= 1'b0;
      page_cur  <= 2'd0;
      frame_cnt <= 16'd0;
      err       <= 1'b0;
      wdog      <= '0;
    end else begin
      if (ld) begin
        s1 <= pg_line[{page_cur, 2'd0}];
        s2 <= pg_line[{page_cur, 2'd1}];
        s3 <= pg_line[{page_cur, 2'd2}];
        s4 <= pg_line[{page_cur, 2'd3}];
      end
      if (ref_set) begin
        refresh <= 1'b1;
      end else if (ref_clr) begin
        refresh <= 1'b0;
      end
      if (err_set) err <= 1'b1;
      if (fc_inc) frame_cnt <= frame_cnt + 16'd1;
      if (page_next) page_cur <= next_page(page_cur, NPAGES);
      if (wd_clr) begin
        wdog <= '0;
      end else if (in_wait) begin
        wdog <= wdog + 1'b1;
      end
    end
  end

endmodule
